// File: rtl/mixedBlockC_package.sv
// Shared item/sum types and accumulator state encoding for the cStuff consumer.
package mixedBlockC_package;

  localparam int unsigned SEE_W = 5;
  localparam int unsigned DST_W = 7;

  typedef logic [SEE_W-1:0] seeSt;
  typedef logic [DST_W-1:0] dSt;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } cstuffAccumStateT;

endpackage

// File: rtl/mixed_package.sv
// Shared constant for the cStuff accumulator: the largest legal group size.
package mixed_package;

  localparam int unsigned CSTUFF_ACC_MAX = 4;

endpackage

// File: rtl/cstuff_fifo.sv
// Small synchronous FIFO with registered full/empty flags and occupancy.
// A push is dropped while full, even if a pop happens in the same cycle.
module cstuff_fifo #(
  parameter type         T     = logic [4:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] count_nxt;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Flags are computed from the next count so they are valid straight out of a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/cstuff_accum.sv
// Sums groups of ACC_N seeSt items from the cStuffIf stream into dSt words, with flush.
// Optional CSTUFF_ACCUM_STATS_EN adds grp_total/part_total emit counters.
module cstuff_accum
  import mixed_package::*;
  import mixedBlockC_package::*;
#(
  parameter int unsigned ACC_N      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cStuffIf_vld,
  input  logic [4:0]  cStuffIf_data,
  output logic        cStuffIf_rdy,
  output logic        dStuffIf_vld,
  output logic [6:0]  dStuffIf_data,
  input  logic        dStuffIf_rdy,
  input  logic        flush,
  output logic [2:0]  grp_cnt
`ifdef CSTUFF_ACCUM_STATS_EN
  ,
  output logic [15:0] grp_total,
  output logic [15:0] part_total
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  if (ACC_N == 0 || ACC_N > CSTUFF_ACC_MAX) begin : g_bad_acc_n
    $error("cstuff_accum: ACC_N must be within 1..%0d", CSTUFF_ACC_MAX);
  end

  cstuffAccumStateT state;
  cstuffAccumStateT state_nxt;
  dSt               acc;
  dSt               acc_nxt;
  dSt               sum;
  dSt               data_nxt;
  logic [2:0]       cnt_nxt;
  logic             flush_pend;
  logic             pend_nxt;
  logic             vld_nxt;
  logic             pop;
  logic             part_emit;
  seeSt             item;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  cstuff_fifo #(
    .T     (seeSt),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cStuffIf_vld),
    .push_data (cStuffIf_data),
    .pop       (pop),
    .pop_data  (item),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cStuffIf_rdy = !fifo_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Next-state logic: queued items always drain before a pending flush is honoured.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = grp_cnt;
    pend_nxt  = flush_pend | flush;
    vld_nxt   = dStuffIf_vld;
    data_nxt  = dStuffIf_data;
    pop       = 1'b0;
    part_emit = 1'b0;
    sum       = acc + DST_W'(item);
    case (state)
      ACCUM: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (grp_cnt + 3'd1 == 3'(ACC_N)) begin
            data_nxt  = sum;
            vld_nxt   = 1'b1;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = EMIT;
          end else begin
            acc_nxt = sum;
            cnt_nxt = grp_cnt + 3'd1;
          end
        end else if (flush_pend) begin
          pend_nxt = flush;
          if (grp_cnt != '0) begin
            data_nxt  = acc;
            vld_nxt   = 1'b1;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            part_emit = 1'b1;
            state_nxt = EMIT;
          end
        end
      end
      EMIT: begin
        if (dStuffIf_rdy) begin
          vld_nxt   = 1'b0;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      grp_cnt       <= '0;
      flush_pend    <= 1'b0;
      dStuffIf_vld  <= 1'b0;
      dStuffIf_data <= '0;
    end else begin
      acc           <= acc_nxt;
      grp_cnt       <= cnt_nxt;
      flush_pend    <= pend_nxt;
      dStuffIf_vld  <= vld_nxt;
      dStuffIf_data <= data_nxt;
    end
  end

`ifdef CSTUFF_ACCUM_STATS_EN
  // Free-running 16-bit counters; wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_total  <= '0;
      part_total <= '0;
    end else begin
      if (dStuffIf_vld && dStuffIf_rdy) grp_total <= grp_total + 16'd1;
      if (part_emit) part_total <= part_total + 16'd1;
    end
  end
`endif

  a_full_count : assert property (@(posedge clk) disable iff (rst)
    fifo_full |-> (fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_cstuff_accum.sv
// Self-checking bench for cstuff_accum: directed scenarios plus randomized batches
// checked against a queue-based group-sum model.
module tb_cstuff_accum;

  localparam int ACC_N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cStuffIf_vld;
  logic [4:0] cStuffIf_data;
  logic       cStuffIf_rdy;
  logic       dStuffIf_vld;
  logic [6:0] dStuffIf_data;
  logic       dStuffIf_rdy;
  logic       flush;
  logic [2:0] grp_cnt;
`ifdef CSTUFF_ACCUM_STATS_EN
  logic [15:0] grp_total;
  logic [15:0] part_total;
`endif

  cstuff_accum #(.ACC_N(ACC_N), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cStuffIf_vld  (cStuffIf_vld),
    .cStuffIf_data (cStuffIf_data),
    .cStuffIf_rdy  (cStuffIf_rdy),
    .dStuffIf_vld  (dStuffIf_vld),
    .dStuffIf_data (dStuffIf_data),
    .dStuffIf_rdy  (dStuffIf_rdy),
    .flush         (flush),
    .grp_cnt       (grp_cnt)
`ifdef CSTUFF_ACCUM_STATS_EN
    ,
    .grp_total     (grp_total),
    .part_total    (part_total)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int cur[$];
  bit rand_rdy  = 1'b0;
  bit prev_hold = 1'b0;
  int prev_data = 0;
  int mdl_grp   = 0;
  int mdl_part  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: items form groups of ACC_N; a flush closes a non-empty partial group.
  task automatic model_push(input int v);
    cur.push_back(v);
    if (cur.size() == ACC_N) begin
      exp_q.push_back(cur.sum());
      cur.delete();
    end
  endtask

  task automatic model_flush();
    if (cur.size() > 0) begin
      exp_q.push_back(cur.sum());
      mdl_part++;
      cur.delete();
    end
  endtask

  // Output-side checks, sampled at the falling edge.
  task automatic monitor();
    if (prev_hold) begin
      chk("hold_vld", int'(dStuffIf_vld), 1);
      chk("hold_data", int'(dStuffIf_data), prev_data);
    end
    if (dStuffIf_vld && dStuffIf_rdy) begin
      if (exp_q.size() == 0) chk("unexpected_out", int'(dStuffIf_data), -1);
      else begin
        chk("out_data", int'(dStuffIf_data), exp_q.pop_front());
        mdl_grp++;
      end
    end
    prev_hold = dStuffIf_vld && !dStuffIf_rdy;
    prev_data = int'(dStuffIf_data);
  endtask

  task automatic cyc(output bit in_hs);
    @(negedge clk);
    in_hs = cStuffIf_vld && cStuffIf_rdy;
    if (!rst) monitor();
    @(posedge clk);
    #1;
    if (rand_rdy) dStuffIf_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic ticks(input int n);
    bit a;
    repeat (n) cyc(a);
  endtask

  task automatic push(input int v);
    bit done = 1'b0;
    cStuffIf_vld  = 1'b1;
    cStuffIf_data = 5'(v);
    for (int i = 0; i < 200 && !done; i++) cyc(done);
    cStuffIf_vld = 1'b0;
    if (done) model_push(v);
    else chk("push_timeout", int'(done), 1);
  endtask

  task automatic pulse_flush();
    bit a;
    flush = 1'b1;
    cyc(a);
    flush = 1'b0;
    model_flush();
  endtask

  task automatic drain();
    bit a;
    int n = 0;
    while ((exp_q.size() != 0 || dStuffIf_vld) && n < 300) begin
      cyc(a);
      n++;
    end
    chk("drain_timeout", int'(n < 300), 1);
    ticks(6);
    chk("grp_cnt", int'(grp_cnt), cur.size());
  endtask

  initial begin
    cStuffIf_vld  = 1'b0;
    cStuffIf_data = '0;
    dStuffIf_rdy  = 1'b1;
    flush         = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dvld", int'(dStuffIf_vld), 0);
    chk("rst_ddata", int'(dStuffIf_data), 0);
    chk("rst_crdy", int'(cStuffIf_rdy), 1);
    chk("rst_grp", int'(grp_cnt), 0);
    rst = 1'b0;
    ticks(1);

    // Basic group and its latency
    push(3); push(5); push(7); push(9);
    chk("lat_vld_early", int'(dStuffIf_vld), 0);
    ticks(1);
    chk("lat_vld", int'(dStuffIf_vld), 1);
    chk("lat_data", int'(dStuffIf_data), 24);
    drain();

    // Maximum values
    push(31); push(31); push(31); push(31);
    drain();

    // Backpressure: one sum held, FIFO full behind it
    dStuffIf_rdy = 1'b0;
    repeat (8) push(1);
    ticks(3);
    chk("bp_crdy", int'(cStuffIf_rdy), 0);
    chk("bp_vld", int'(dStuffIf_vld), 1);
    chk("bp_data", int'(dStuffIf_data), 4);
    dStuffIf_rdy = 1'b1;
    repeat (4) push(1);
    drain();

    // Partial flush then a fresh group
    push(2); push(6);
    pulse_flush();
    drain();
    repeat (4) push(1);
    drain();

    // Flush with an empty group emits nothing
    pulse_flush();
    ticks(5);
    chk("flush_empty_vld", int'(dStuffIf_vld), 0);

    // Flush during EMIT hold with queued items
    dStuffIf_rdy = 1'b0;
    repeat (4) push(1);
    push(10); push(10);
    ticks(2);
    pulse_flush();
    ticks(3);
    chk("emit_hold_vld", int'(dStuffIf_vld), 1);
    chk("emit_hold_data", int'(dStuffIf_data), 4);
    dStuffIf_rdy = 1'b1;
    drain();
    push(5);
    ticks(8);
    chk("pend_cleared_vld", int'(dStuffIf_vld), 0);
    chk("pend_cleared_grp", int'(grp_cnt), 1);
    push(5); push(5); push(5);
    drain();

    // Randomized batches with random backpressure
    rand_rdy = 1'b1;
    for (int b = 0; b < 40; b++) begin
      int n = int'($urandom_range(0, 7));
      for (int k = 0; k < n; k++) begin
        ticks(int'($urandom_range(0, 2)));
        push(int'($urandom_range(0, 31)));
      end
      if ($urandom_range(0, 1) == 1) pulse_flush();
      drain();
    end
    rand_rdy     = 1'b0;
    dStuffIf_rdy = 1'b1;
    pulse_flush();
    drain();

    // Mid-operation reset discards the partial group
    push(4); push(4); push(4);
    ticks(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur.delete();
    exp_q.delete();
    prev_hold = 1'b0;
    mdl_grp   = 0;
    mdl_part  = 0;
    chk("mrst_vld", int'(dStuffIf_vld), 0);
    chk("mrst_grp", int'(grp_cnt), 0);
    chk("mrst_crdy", int'(cStuffIf_rdy), 1);
    repeat (4) push(1);
    drain();
    chk("mrst_outs", mdl_grp, 1);
`ifdef CSTUFF_ACCUM_STATS_EN
    chk("grp_total", int'(grp_total), mdl_grp);
    chk("part_total", int'(part_total), mdl_part);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
